// File: rtl/accum_pkg.sv
// ---------------------------------------------------------------------------
// accum_pkg : shared types and defaults for the windowed accumulator
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package accum_pkg;

   localparam int DEF_ISIZE = 8;
   localparam int DEF_DSIZE = 16;
   localparam int CNT_W     = 8;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } state_e;

endpackage

`default_nettype wire

// File: rtl/sat_add_u.sv
// ---------------------------------------------------------------------------
// sat_add_u : DSIZE-bit unsigned saturating adder with carry-out
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sat_add_u #(
   parameter int DSIZE = 16
) (
   input  logic [DSIZE-1:0] a_i,
   input  logic [DSIZE-1:0] b_i,
   output logic [DSIZE-1:0] sum_o,
   output logic             carry_o
);

   localparam logic [DSIZE-1:0] C_ONES = {DSIZE{1'b1}};

   logic [DSIZE:0] w_full;

   assign w_full  = {1'b0, a_i} + {1'b0, b_i};
   assign carry_o = w_full[DSIZE];
   assign sum_o   = w_full[DSIZE] ? C_ONES : w_full[DSIZE-1:0];

endmodule

`default_nettype wire

// File: rtl/accum_window.sv
// ---------------------------------------------------------------------------
// accum_window : sums windows of win_len samples into saturating totals
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module accum_window
   import accum_pkg::*;
#(
   parameter int ISIZE = DEF_ISIZE,
   parameter int DSIZE = DEF_DSIZE,
   parameter int LSIZE = CNT_W
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             clear,
   input  logic [LSIZE-1:0] win_len,
   input  logic [ISIZE-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [DSIZE-1:0] out_data,
   output logic             out_ovf,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam logic [LSIZE-1:0] C_ONE = {{(LSIZE-1){1'b0}}, 1'b1};

   state_e             state_q, state_d;
   logic [LSIZE-1:0]   len_q, len_d;
   logic [LSIZE-1:0]   cnt_q, cnt_d;
   logic [DSIZE-1:0]   acc_q, acc_d;
   logic               ovf_q, ovf_d;
   logic [DSIZE-1:0]   out_data_q, out_data_d;
   logic               out_ovf_q, out_ovf_d;
   logic               out_valid_q, out_valid_d;

   logic [LSIZE-1:0]   w_len_in;
   logic [LSIZE-1:0]   w_len_m1;
   logic               w_last;
   logic               w_accept;
   logic               w_emit;
   logic [DSIZE-1:0]   w_add_a;
   logic [DSIZE-1:0]   w_in_ext;
   logic [DSIZE-1:0]   w_sum;
   logic               w_carry;
   logic               w_ovf_win;

   assign w_len_in = (win_len == '0) ? C_ONE : win_len;
   assign w_len_m1 = len_q - C_ONE;
   assign w_last   = (state_q == ST_IDLE) ? (w_len_in == C_ONE) : (cnt_q == w_len_m1);

   // Stall only the window-closing sample, and only while the output slot stays full.
   assign in_ready = rst_n & ~(w_last & out_valid_q & ~out_ready);
   assign w_accept = in_valid & in_ready;
   assign w_emit   = w_accept & ~clear & w_last;

   assign w_in_ext  = {{(DSIZE-ISIZE){1'b0}}, in_data};
   assign w_add_a   = (state_q == ST_ACCUM) ? acc_q : '0;
   assign w_ovf_win = ((state_q == ST_ACCUM) & ovf_q) | w_carry;

   sat_add_u #(
      .DSIZE (DSIZE)
   ) u_sat_add (
      .a_i     (w_add_a),
      .b_i     (w_in_ext),
      .sum_o   (w_sum),
      .carry_o (w_carry)
   );

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      out_data_d  = out_data_q;
      out_ovf_d   = out_ovf_q;
      out_valid_d = out_valid_q;

      if (clear) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         acc_d   = '0;
         ovf_d   = 1'b0;
      end else if (w_accept) begin
         acc_d   = w_sum;
         ovf_d   = w_ovf_win;
         cnt_d   = cnt_q + C_ONE;
         if (state_q == ST_IDLE) begin
            len_d = w_len_in;
            cnt_d = C_ONE;
         end
         state_d = w_last ? ST_IDLE : ST_ACCUM;
      end

      // A new total overrides the transfer of the previous one in the same cycle.
      if (w_emit) begin
         out_data_d  = w_sum;
         out_ovf_d   = w_ovf_win;
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         len_q       <= C_ONE;
         cnt_q       <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         out_data_q  <= '0;
         out_ovf_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         out_data_q  <= out_data_d;
         out_ovf_q   <= out_ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_ovf   = out_ovf_q;
   assign out_valid = out_valid_q;

endmodule

`default_nettype wire
